battle_turn_ctrl: RTL

Turn scheduler for the battle screen. Sequences the game between player-menu turns and timed monster-dodge phases, and owns character and monster HP. Drives the 2-bit game-state code consumed by the renderer and bullet logic. Sits between the menu/keyboard decode and the dodge-arena datapath, replacing free-running turn timing with an explicit FSM.

---
 rtl/battle_pkg.sv | 24 ++
 rtl/phase_timer.sv | 37 +++
 rtl/battle_turn_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/battle_pkg.sv
// Shared types and constants for the battle turn scheduler.
// Optional grace window is enabled with BATTLE_GRACE_EN (see battle_turn_ctrl).
package battle_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLAYER,
      S_RESOLVE,
      S_DODGE,
      S_OVER
   } state_t;

   localparam logic [1:0] GS_DODGE  = 2'd0;
   localparam logic [1:0] GS_PLAYER = 2'd1;
   localparam logic [1:0] GS_IDLE   = 2'd2;

   localparam int DEF_DODGE_CYCLES = 125000000;
   localparam int DEF_CNT_W        = 27;
   localparam int DEF_HP_W         = 8;
   localparam int DEF_CHAR_HP_MAX  = 20;
   localparam int DEF_MON_HP_MAX   = 100;
   localparam int DEF_GRACE_CYCLES = 50000000;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that holds at zero; o_done flags the terminal count.
module phase_timer #(
   parameter int W = 27
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic [W-1:0] o_count,
   output logic         o_done
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_load) begin
         count_d = i_load_val;
      end else if (i_en && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count = count_q;
   assign o_done  = (count_q == '0);

endmodule

// File: rtl/battle_turn_ctrl.sv
// Battle turn scheduler: player menu turns, timed dodge phases, HP ownership.
// Define BATTLE_GRACE_EN to add a post-hit invulnerability window and o_grace.
//
// state     | meaning
// S_IDLE    | title screen, waiting for i_start
// S_PLAYER  | player menu turn, waiting for i_attack
// S_RESOLVE | apply latched damage to the monster
// S_DODGE   | timed bullet phase, character can be hit
// S_OVER    | battle finished, o_win tells who won
module battle_turn_ctrl
   import battle_pkg::*;
#(
   parameter int DODGE_CYCLES = DEF_DODGE_CYCLES,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int HP_W         = DEF_HP_W,
   parameter int CHAR_HP_MAX  = DEF_CHAR_HP_MAX,
   parameter int MON_HP_MAX   = DEF_MON_HP_MAX
`ifdef BATTLE_GRACE_EN
   ,
   parameter int GRACE_CYCLES = DEF_GRACE_CYCLES
`endif
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_attack,
   input  logic [HP_W-1:0]  i_dmg,
   input  logic             i_hit,
   input  logic [HP_W-1:0]  i_hit_dmg,
   output logic [1:0]       o_state_game,
   output logic [HP_W-1:0]  o_char_hp,
   output logic [HP_W-1:0]  o_mon_hp,
   output logic             o_char_alive,
   output logic             o_mon_alive,
   output logic             o_win,
`ifdef BATTLE_GRACE_EN
   output logic             o_grace,
`endif
   output logic [CNT_W-1:0] o_time_left
);

   function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                               input logic [HP_W-1:0] b);
      return (b >= a) ? '0 : a - b;
   endfunction

   state_t          state_q, state_d;
   logic [HP_W-1:0] char_hp_q, char_hp_d;
   logic [HP_W-1:0] mon_hp_q, mon_hp_d;
   logic [HP_W-1:0] dmg_q, dmg_d;
   logic            win_q, win_d;

   logic [HP_W-1:0]  res_hp;
   logic [HP_W-1:0]  hit_hp;
   logic             hit_ok;
   logic             dt_load;
   logic [CNT_W-1:0] dt_count;
   logic             dt_done;

   always_comb begin
      state_d   = state_q;
      char_hp_d = char_hp_q;
      mon_hp_d  = mon_hp_q;
      dmg_d     = dmg_q;
      win_d     = win_q;
      dt_load   = 1'b0;
      res_hp    = sat_sub(mon_hp_q, dmg_q);
      hit_hp    = sat_sub(char_hp_q, i_hit_dmg);
      case (state_q)
         S_IDLE, S_OVER: begin
            if (i_start) begin
               char_hp_d = HP_W'(CHAR_HP_MAX);
               mon_hp_d  = HP_W'(MON_HP_MAX);
               win_d     = 1'b0;
               state_d   = S_PLAYER;
            end
         end
         S_PLAYER: begin
            if (i_attack) begin
               dmg_d   = i_dmg;
               state_d = S_RESOLVE;
            end
         end
         S_RESOLVE: begin
            mon_hp_d = res_hp;
            if (res_hp == '0) begin
               win_d   = 1'b1;
               state_d = S_OVER;
            end else begin
               dt_load = 1'b1;
               state_d = S_DODGE;
            end
         end
         S_DODGE: begin
            if (hit_ok) begin
               char_hp_d = hit_hp;
            end
            // A fatal hit wins over the phase ending in the same cycle.
            if (hit_ok && (hit_hp == '0)) begin
               win_d   = 1'b0;
               state_d = S_OVER;
            end else if (dt_done) begin
               state_d = S_PLAYER;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         char_hp_q <= HP_W'(CHAR_HP_MAX);
         mon_hp_q  <= HP_W'(MON_HP_MAX);
         dmg_q     <= '0;
         win_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         char_hp_q <= char_hp_d;
         mon_hp_q  <= mon_hp_d;
         dmg_q     <= dmg_d;
         win_q     <= win_d;
      end
   end

   phase_timer #(.W(CNT_W)) u_dodge_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (dt_load),
      .i_load_val (CNT_W'(DODGE_CYCLES - 1)),
      .i_en       (state_q == S_DODGE),
      .o_count    (dt_count),
      .o_done     (dt_done)
   );

`ifdef BATTLE_GRACE_EN
   logic             gr_load;
   logic [CNT_W-1:0] gr_val;
   logic [CNT_W-1:0] gr_count;
   logic             gr_done;

   assign hit_ok = i_hit && gr_done;

   // Window is cleared whenever the next cycle is not a dodge cycle.
   always_comb begin
      gr_load = 1'b0;
      gr_val  = '0;
      if (state_d != S_DODGE) begin
         gr_load = 1'b1;
      end else if (hit_ok) begin
         gr_load = 1'b1;
         gr_val  = CNT_W'(GRACE_CYCLES);
      end
   end

   phase_timer #(.W(CNT_W)) u_grace_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (gr_load),
      .i_load_val (gr_val),
      .i_en       (state_q == S_DODGE),
      .o_count    (gr_count),
      .o_done     (gr_done)
   );

   assign o_grace = (gr_count != '0);
`else
   assign hit_ok = i_hit;
`endif

   always_comb begin
      o_state_game = GS_IDLE;
      case (state_q)
         S_PLAYER, S_RESOLVE: o_state_game = GS_PLAYER;
         S_DODGE:             o_state_game = GS_DODGE;
         default:             o_state_game = GS_IDLE;
      endcase
   end

   assign o_char_hp    = char_hp_q;
   assign o_mon_hp     = mon_hp_q;
   assign o_char_alive = (char_hp_q != '0);
   assign o_mon_alive  = (mon_hp_q != '0);
   assign o_win        = win_q;
   assign o_time_left  = (state_q == S_DODGE) ? dt_count : '0;

endmodule
